// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Brief    : Shared constants for the seven-segment scan driver: segment
//            patterns for hex digits 0..F, the all-dark code and the number
//            of brightness phases per digit slot.
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // Brightness resolution: each slot is split into this many phases
    localparam int c_PHASE_COUNT = 16;

    // Cathode code for a dark digit (active-low, everything off)
    localparam logic [7:0] c_SEG_BLANK = 8'hFF;

    // {dp,a,b,c,d,e,f,g}, active low, dp off; entry i is the glyph for hex i
    localparam logic [15:0][7:0] c_SEG_PATTERN = {
        8'hB8, 8'hB0, 8'hC2, 8'hB1, 8'hE0, 8'h88, 8'h8C, 8'h80,
        8'h8F, 8'hA0, 8'hA4, 8'hCC, 8'h86, 8'h92, 8'hCF, 8'h81
    };

endpackage
`default_nettype wire

// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver_if
// Brief    : Display data/control bundle between a host and the scan driver.
//            Signal prefixes are from the driver's point of view.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] i_value;
    logic [NUM_DIGITS-1:0]   i_dp;
    logic                    i_ld;
    logic [NUM_DIGITS-1:0]   i_en;
    logic                    i_lzb;
    logic [3:0]              i_bright;
    logic [7:0]              o_cathodes;
    logic [NUM_DIGITS-1:0]   o_anodes;
    logic                    o_frame;

    modport master (
        output i_value, i_dp, i_ld, i_en, i_lzb, i_bright,
        input  o_cathodes, o_anodes, o_frame
    );

    modport slave (
        input  i_value, i_dp, i_ld, i_en, i_lzb, i_bright,
        output o_cathodes, o_anodes, o_frame
    );
endinterface
`default_nettype wire

// File: rtl/seg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_decoder
// Brief    : Combinational hex nibble + decimal point to active-low cathodes.
// Revision : 1.0 - initial release
// ============================================================================
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output logic [7:0] o_cathodes
);

    // Look up the glyph, then pull the dp cathode low when the point is lit
    always_comb begin
        o_cathodes = c_SEG_PATTERN[i_nibble];
        if (i_dp) begin
            o_cathodes[7] = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Brief    : Multiplexed seven-segment scan driver with shadowed display data,
//            per-digit enables, leading-zero blanking, 16-step PWM brightness
//            and a one-cycle dead time at the start of every digit slot.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SLOT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_driver_if.slave  bus
);

    localparam int c_CNT_W  = $clog2(SLOT_CYCLES);
    localparam int c_DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_PDIV   = SLOT_CYCLES / c_PHASE_COUNT;
    localparam int c_PDIV_W = $clog2(c_PDIV);

    localparam logic [c_CNT_W-1:0]  c_CNT_MAX  = c_CNT_W'(SLOT_CYCLES - 1);
    localparam logic [c_DIG_W-1:0]  c_DIG_MAX  = c_DIG_W'(NUM_DIGITS - 1);
    localparam logic [c_PDIV_W-1:0] c_PDIV_MAX = c_PDIV_W'(c_PDIV - 1);

    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_PDIV_W-1:0]     r_pcnt;
    logic [3:0]              r_phase;
    logic [c_DIG_W-1:0]      r_dig;
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [7:0]              r_cathodes;
    logic [NUM_DIGITS-1:0]   r_anodes;
    logic                    r_frame;

    logic                    w_wrap;
    logic                    w_last_slot;
    logic [3:0]              w_nib;
    logic                    w_dp;
    logic [7:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic                    w_allz;
    logic                    w_lit;
    logic [NUM_DIGITS-1:0]   w_anodes_nxt;

    assign w_wrap      = (r_cnt == c_CNT_MAX);
    assign w_last_slot = w_wrap && (r_dig == c_DIG_MAX);

    // Slot counter, phase sub-counter (avoids a divider) and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_pcnt  <= '0;
            r_phase <= '0;
            r_dig   <= '0;
        end else if (w_wrap) begin
            r_cnt   <= '0;
            r_pcnt  <= '0;
            r_phase <= '0;
            r_dig   <= (r_dig == c_DIG_MAX) ? '0 : r_dig + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_pcnt == c_PDIV_MAX) begin
                r_pcnt  <= '0;
                r_phase <= r_phase + 1'b1;
            end else begin
                r_pcnt <= r_pcnt + 1'b1;
            end
        end
    end

    // Shadow registers: the scan only ever reads these, never the live inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
            r_dp    <= '0;
        end else if (bus.i_ld) begin
            r_value <= bus.i_value;
            r_dp    <= bus.i_dp;
        end
    end

    // Leading-zero blanking: walk down from the top digit tracking "all zero so far"
    always_comb begin
        w_allz  = 1'b1;
        w_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_allz     = w_allz & (r_value[4*i +: 4] == 4'd0);
            w_blank[i] = bus.i_lzb & w_allz & (i != 0);
        end
    end

    assign w_nib = r_value[4*r_dig +: 4];
    assign w_dp  = r_dp[r_dig];

    seg_decoder u_decoder (
        .i_nibble   (w_nib),
        .i_dp       (w_dp),
        .o_cathodes (w_seg)
    );

    // Selected digit is lit only when enabled, unblanked, inside its PWM window
    // and past the first (dead) cycle of the slot
    always_comb begin
        w_lit        = bus.i_en[r_dig] & ~w_blank[r_dig] &
                       (r_phase <= bus.i_bright) & (r_cnt != '0);
        w_anodes_nxt = '1;
        if (w_lit) begin
            w_anodes_nxt[r_dig] = 1'b0;
        end
    end

    // Registered pin drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_anodes   <= '1;
            r_cathodes <= c_SEG_BLANK;
            r_frame    <= 1'b0;
        end else begin
            r_anodes   <= w_anodes_nxt;
            r_cathodes <= w_lit ? w_seg : c_SEG_BLANK;
            r_frame    <= w_last_slot;
        end
    end

    assign bus.o_anodes   = r_anodes;
    assign bus.o_cathodes = r_cathodes;
    assign bus.o_frame    = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Brief    : Scoreboard bench for seg_scan_driver (4 digits, 32-cycle slots).
//            Stimulus queues hand-computed pin values tagged with the clock
//            edge (counted from reset release) after which they must appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int c_ND   = 4;
    localparam int c_SLOT = 32;

    typedef struct {
        int         n;
        logic [3:0] an;
        logic [7:0] cat;
        logic       fr;
    } exp_t;

    logic clk;
    logic rst_n;
    logic done;
    int   cyc;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    exp_t e;

    seg_scan_driver_if #(.NUM_DIGITS(c_ND)) bus ();

    seg_scan_driver #(
        .NUM_DIGITS  (c_ND),
        .SLOT_CYCLES (c_SLOT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edges since reset release; pins after edge n reflect slot position n-1
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, queue depth %0d, required 0", q.size());
        $fatal(1, "watchdog");
    end

    task automatic push(input int n, input logic [3:0] an, input logic [7:0] cat);
        exp_t x;
        x.n   = n;
        x.an  = an;
        x.cat = cat;
        x.fr  = (n % 128 == 0);
        q.push_back(x);
    endtask

    // Expected pins for a handful of positions inside slot s
    task automatic push_slot(input int s, input logic [7:0] cat, input bit lit, input int br);
        int         cs[7] = '{0, 1, 2, 3, 15, 16, 31};
        logic [3:0] sel;
        bit         l;
        foreach (cs[k]) begin
            l   = lit && (cs[k] != 0) && ((cs[k] / 2) <= br);
            sel = 4'b0001 << (s % 4);
            push(s*c_SLOT + cs[k] + 1, l ? ~sel : 4'hF, l ? cat : 8'hFF);
        end
    endtask

    task automatic wait_n(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Load new shadow data for frame k (LD seen at edge 128k) and change
    // live controls right after edge 128k, so the whole frame uses them
    task automatic setup_frame(input int k, input logic [15:0] val, input logic [3:0] dp,
                               input logic [3:0] en, input logic lzb, input logic [3:0] br,
                               input bit do_ld);
        wait_n(128*k - 1);
        if (do_ld) begin
            bus.i_value = val;
            bus.i_dp    = dp;
            bus.i_ld    = 1'b1;
        end
        wait_n(128*k);
        bus.i_ld     = 1'b0;
        bus.i_en     = en;
        bus.i_lzb    = lzb;
        bus.i_bright = br;
    endtask

    // Monitor: reset values while in reset, scoreboard entries otherwise
    always begin : mon
        @(negedge clk or negedge rst_n);
        #1;
        if (!rst_n) begin
            n_checks++;
            if (bus.o_anodes !== 4'hF || bus.o_cathodes !== 8'hFF || bus.o_frame !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: anodes=%h cathodes=%h frame=%b, required F/FF/0",
                         bus.o_anodes, bus.o_cathodes, bus.o_frame);
            end
        end else begin
            while (q.size() > 0 && q[0].n <= cyc) begin
                e = q.pop_front();
                n_checks++;
                if (e.n != cyc) begin
                    n_fail++;
                    $display("FAIL missed_sample: edge %0d checked at edge %0d", e.n, cyc);
                end else if (bus.o_anodes !== e.an || bus.o_cathodes !== e.cat ||
                             bus.o_frame !== e.fr) begin
                    n_fail++;
                    $display("FAIL pins@%0d: anodes=%h cathodes=%h frame=%b, required %h/%h/%b",
                             cyc, bus.o_anodes, bus.o_cathodes, bus.o_frame, e.an, e.cat, e.fr);
                end
            end
        end
        if (done) begin
            n_checks++;
            if (q.size() != 0) begin
                n_fail++;
                $display("FAIL queue_drain: %0d entries left, required 0", q.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        done         = 1'b0;
        rst_n        = 1'b1;
        bus.i_value  = '0;
        bus.i_dp     = '0;
        bus.i_ld     = 1'b0;
        bus.i_en     = 4'hF;
        bus.i_lzb    = 1'b0;
        bus.i_bright = 4'd15;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);

        // Frame 0: 1234, full brightness
        bus.i_value = 16'h1234;
        bus.i_ld    = 1'b1;
        push_slot(0, 8'hCC, 1, 15);
        push_slot(1, 8'h86, 1, 15);
        push_slot(2, 8'h92, 1, 15);
        push_slot(3, 8'hCF, 1, 15);
        #2 rst_n = 1'b1;
        wait_n(1);
        bus.i_ld = 1'b0;

        // Frame 1: 0050 with leading-zero blanking
        setup_frame(1, 16'h0050, 4'b0000, 4'hF, 1'b1, 4'd15, 1);
        push_slot(4, 8'h81, 1, 15);
        push_slot(5, 8'hA4, 1, 15);
        push_slot(6, 8'hFF, 0, 15);
        push_slot(7, 8'hFF, 0, 15);

        // Frame 2: 0000 with blanking, only digit 0 remains
        setup_frame(2, 16'h0000, 4'b0000, 4'hF, 1'b1, 4'd15, 1);
        push_slot(8,  8'h81, 1, 15);
        push_slot(9,  8'hFF, 0, 15);
        push_slot(10, 8'hFF, 0, 15);
        push_slot(11, 8'hFF, 0, 15);

        // Frame 3: minimum brightness
        setup_frame(3, 16'h1234, 4'b0000, 4'hF, 1'b0, 4'd0, 1);
        push_slot(12, 8'hCC, 1, 0);
        push_slot(13, 8'h86, 1, 0);
        push_slot(14, 8'h92, 1, 0);
        push_slot(15, 8'hCF, 1, 0);

        // Frame 4: half brightness
        setup_frame(4, 16'h1234, 4'b0000, 4'hF, 1'b0, 4'd7, 1);
        push_slot(16, 8'hCC, 1, 7);
        push_slot(17, 8'h86, 1, 7);
        push_slot(18, 8'h92, 1, 7);
        push_slot(19, 8'hCF, 1, 7);

        // Frame 5: 8888 with digit 2 decimal point
        setup_frame(5, 16'h8888, 4'b0100, 4'hF, 1'b0, 4'd15, 1);
        push_slot(20, 8'h80, 1, 15);
        push_slot(21, 8'h80, 1, 15);
        push_slot(22, 8'h00, 1, 15);
        push_slot(23, 8'h80, 1, 15);

        // Frame 6: digit 2 disabled
        setup_frame(6, 16'h8888, 4'b0100, 4'b1011, 1'b0, 4'd15, 1);
        push_slot(24, 8'h80, 1, 15);
        push_slot(25, 8'h80, 1, 15);
        push_slot(26, 8'hFF, 0, 15);
        push_slot(27, 8'h80, 1, 15);

        // Frame 7: VALUE moves without LD, then LD 5555 mid-slot of digit 1
        setup_frame(7, 16'h0000, 4'b0000, 4'hF, 1'b0, 4'd15, 0);
        bus.i_value = 16'h1111;
        push_slot(28, 8'h80, 1, 15);
        push(29*c_SLOT + 2,  4'hD, 8'h80);
        push(29*c_SLOT + 10, 4'hD, 8'h80);
        push(29*c_SLOT + 11, 4'hD, 8'hA4);
        push(29*c_SLOT + 32, 4'hD, 8'hA4);
        push_slot(30, 8'h24, 1, 15);
        push_slot(31, 8'hA4, 1, 15);
        wait_n(29*c_SLOT + 9);
        bus.i_value = 16'h5555;
        bus.i_ld    = 1'b1;
        wait_n(29*c_SLOT + 10);
        bus.i_ld    = 1'b0;

        // Frame 8: reload 1234, then asynchronous reset inside digit 2's slot
        setup_frame(8, 16'h1234, 4'b0000, 4'hF, 1'b0, 4'd15, 1);
        push_slot(32, 8'hCC, 1, 15);
        push_slot(33, 8'h86, 1, 15);
        wait_n(34*c_SLOT + 6);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        // Shadow was cleared: every digit shows 0 and scanning restarts at digit 0
        push_slot(0, 8'h81, 1, 15);
        push_slot(1, 8'h81, 1, 15);
        wait_n(2*c_SLOT + 6);
        done = 1'b1;
        forever @(posedge clk);
    end

endmodule
`default_nettype wire
